// File: rtl/nes_controller_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nes_controller_reader
//
// Serial reader for an NES game controller. Each enable pulse (60 Hz poll
// request) runs one poll of the controller:
//   1. nes_latch is driven high for LATCH_CYCLES clocks.
//   2. A low gap of HALF_CYCLES clocks follows, and bit 0 (A) is sampled at
//      its end.
//   3. Seven nes_clock pulses follow, each HALF_CYCLES high and HALF_CYCLES
//      low. One further bit is sampled at the end of each low phase.
//   4. The assembled byte is published on buttons with a one-cycle valid.
//
// Ports:
//   clock     : system clock (50 MHz)
//   reset_n   : synchronous active-low reset
//   enable    : one-cycle poll request; ignored unless the reader is idle
//   nes_data  : controller serial data, active-low, asynchronous to clock
//   nes_latch : controller latch, active-high
//   nes_clock : controller shift clock, idles low
//   buttons   : last complete poll result, 1 = pressed
//               [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   valid     : one-cycle pulse when buttons has just been updated
//   busy      : high while a poll is in progress
// -----------------------------------------------------------------------------
module nes_controller_reader #(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int CNT_W        = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clock,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LAT_LOW,
        CLK_HIGH,
        CLK_LOW,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             sync_meta_reg;
    logic             sync_reg;
    logic             sample;

    // Two-flop synchronizer. Resets to 1, the released level of the line,
    // so a reset never looks like a pressed button.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_meta_reg <= 1'b1;
            sync_reg      <= 1'b1;
        end else begin
            sync_meta_reg <= nes_data;
            sync_reg      <= sync_meta_reg;
        end
    end

    // Controller data is active-low; internally pressed = 1.
    assign sample = ~sync_reg;

    // Poll sequencer. Outputs are registered and updated together with the
    // state they belong to, so they are valid during the whole state.
    // The phase counter restarts from 0 on every state change.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
            nes_latch   <= 1'b0;
            nes_clock   <= 1'b0;
            buttons     <= 8'h00;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= LATCH;
                        cnt_reg   <= '0;
                        nes_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                LATCH: begin
                    if (cnt_reg == LATCH_LAST) begin
                        state_reg <= LAT_LOW;
                        cnt_reg   <= '0;
                        nes_latch <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                // The controller presents A as soon as the latch is released,
                // so it is sampled at the end of this gap.
                LAT_LOW: begin
                    if (cnt_reg == HALF_LAST) begin
                        shift_reg[0] <= sample;
                        bit_idx_reg  <= 3'd1;
                        state_reg    <= CLK_HIGH;
                        cnt_reg      <= '0;
                        nes_clock    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                CLK_HIGH: begin
                    if (cnt_reg == HALF_LAST) begin
                        state_reg <= CLK_LOW;
                        cnt_reg   <= '0;
                        nes_clock <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                // Sampling at the end of the low phase leaves the whole
                // phase for the controller output to settle through the
                // synchronizer.
                CLK_LOW: begin
                    if (cnt_reg == HALF_LAST) begin
                        shift_reg[bit_idx_reg] <= sample;
                        cnt_reg                <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            // Publish with the final bit merged in directly,
                            // so buttons and valid appear together in DONE.
                            state_reg <= DONE;
                            buttons   <= {sample, shift_reg[6:0]};
                            valid     <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            state_reg   <= CLK_HIGH;
                            nes_clock   <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                // One-cycle publish state; enable here is deliberately
                // ignored, so a held enable restarts from the following IDLE.
                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    nes_latch <= 1'b0;
                    nes_clock <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_nes_controller_reader
//
// Directed bench for nes_controller_reader. Two instances share clock and
// reset: a small one (LATCH_CYCLES=4, HALF_CYCLES=2) for detailed timing and
// corner cases, and one with default parameters for real-time widths.
// Each instance is fed by a behavioural controller: a shift register loaded
// on the rising latch and shifted on each rising nes_clock, driving its LSB
// inverted onto nes_data.
// -----------------------------------------------------------------------------
module tb_nes_controller_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // small instance
    logic       en_s, data_s, latch_s, nclk_s, valid_s, busy_s;
    logic [7:0] btn_s;
    // default instance
    logic       en_d, data_d, latch_d, nclk_d, valid_d, busy_d;
    logic [7:0] btn_d;

    nes_controller_reader #(
        .LATCH_CYCLES(4),
        .HALF_CYCLES (2),
        .CNT_W       (10)
    ) dut_small (
        .clock    (clk),
        .reset_n  (rst_n),
        .enable   (en_s),
        .nes_data (data_s),
        .nes_latch(latch_s),
        .nes_clock(nclk_s),
        .buttons  (btn_s),
        .valid    (valid_s),
        .busy     (busy_s)
    );

    nes_controller_reader dut_def (
        .clock    (clk),
        .reset_n  (rst_n),
        .enable   (en_d),
        .nes_data (data_d),
        .nes_latch(latch_d),
        .nes_clock(nclk_d),
        .buttons  (btn_d),
        .valid    (valid_d),
        .busy     (busy_d)
    );

    // ---------------- controller models ----------------
    logic [7:0] pat_s = 8'h00;
    logic [7:0] pat_d = 8'h00;
    logic [7:0] sr_s  = 8'h00;
    logic [7:0] sr_d  = 8'h00;
    logic       force_low = 1'b0;

    always @(posedge latch_s or posedge nclk_s) begin
        if (latch_s) sr_s = pat_s;
        else         sr_s = {1'b0, sr_s[7:1]};
    end
    always @(posedge latch_d or posedge nclk_d) begin
        if (latch_d) sr_d = pat_d;
        else         sr_d = {1'b0, sr_d[7:1]};
    end
    assign data_s = force_low ? 1'b0 : ~sr_s[0];
    assign data_d = ~sr_d[0];

    // ---------------- monitors (sampled at negedge) ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int   lat_hi_s = 0, lat_rise_s = 0, nclk_p_s = 0, busy_c_s = 0, valid_c_s = 0;
    logic prev_lat_s = 1'b0, prev_nclk_s = 1'b0;
    always @(negedge clk) begin
        if (latch_s) lat_hi_s++;
        if (latch_s && !prev_lat_s) lat_rise_s = cyc;
        if (nclk_s && !prev_nclk_s) nclk_p_s++;
        if (busy_s) busy_c_s++;
        if (valid_s) valid_c_s++;
        prev_lat_s  = latch_s;
        prev_nclk_s = nclk_s;
    end

    int   lat_hi_d = 0, nclk_p_d = 0, hi_run_d = 0, last_rise_d = -100000;
    int   hi_min_d = 1000000, hi_max_d = 0, per_min_d = 1000000, per_max_d = 0;
    logic prev_nclk_d = 1'b0;
    always @(negedge clk) begin
        if (latch_d) lat_hi_d++;
        if (nclk_d) hi_run_d++;
        if (nclk_d && !prev_nclk_d) begin
            nclk_p_d++;
            if (cyc - last_rise_d < 1000) begin
                if (cyc - last_rise_d < per_min_d) per_min_d = cyc - last_rise_d;
                if (cyc - last_rise_d > per_max_d) per_max_d = cyc - last_rise_d;
            end
            last_rise_d = cyc;
        end
        if (!nclk_d && prev_nclk_d) begin
            if (hi_run_d < hi_min_d) hi_min_d = hi_run_d;
            if (hi_run_d > hi_max_d) hi_max_d = hi_run_d;
            hi_run_d = 0;
        end
        prev_nclk_d = nclk_d;
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;
    int t0_s = 0, t0_d = 0, v_abs = 0, rel = 0;
    int b_lat, b_nclk, b_busy, b_valid, v1, v2;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic start_s();
        en_s = 1'b1;
        t0_s = cyc + 1;
        step();
        en_s = 1'b0;
    endtask

    task automatic start_d();
        en_d = 1'b1;
        t0_d = cyc + 1;
        step();
        en_d = 1'b0;
    endtask

    // Wait for valid; rel becomes the cycle number relative to the poll
    // start, or -1 if the budget expires (later checks then fail).
    task automatic wait_valid_s(input int budget, output int r);
        r = -1;
        for (int i = 0; i < budget; i++) begin
            if (valid_s) begin
                r = cyc - t0_s + 1;
                v_abs = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic wait_valid_d(input int budget, output int r);
        r = -1;
        for (int i = 0; i < budget; i++) begin
            if (valid_d) begin
                r = cyc - t0_d + 1;
                v_abs = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic snap_s();
        b_lat   = lat_hi_s;
        b_nclk  = nclk_p_s;
        b_busy  = busy_c_s;
        b_valid = valid_c_s;
    endtask

    // Watchdog: the directed sequence is bounded, this only guards a stuck sim.
    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        en_s      = 1'b1;
        en_d      = 1'b0;
        force_low = 1'b1;

        // Reset held with enable and pressed data: nothing may start.
        repeat (3) step();
        check("rst_outs_s", 32'({latch_s, nclk_s, btn_s, valid_s, busy_s}), 32'd0);
        check("rst_outs_d", 32'({latch_d, nclk_d, btn_d, valid_d, busy_d}), 32'd0);
        check("rst_no_latch", 32'(lat_hi_s), 32'd0);
        rst_n     = 1'b1;
        en_s      = 1'b0;
        force_low = 1'b0;
        repeat (5) step();
        check("idle_latch_s", 32'(latch_s), 32'd0);
        check("idle_busy_s", 32'(busy_s), 32'd0);
        $display("reset: outputs idle after release");

        // Default parameters, all released.
        pat_d = 8'h00;
        b_lat = lat_hi_d;
        start_d();
        wait_valid_d(6000, rel);
        check("def_valid_cycle0", 32'(rel), 32'd5101);
        check("def_buttons00", 32'(btn_d), 32'h00);
        check("def_latch_width", 32'(lat_hi_d - b_lat), 32'd600);
        $display("default poll 1: valid at cycle %0d buttons=0x%02h", rel, btn_d);
        repeat (3) step();

        // Default parameters, all pressed.
        pat_d  = 8'hFF;
        b_nclk = nclk_p_d;
        start_d();
        wait_valid_d(6000, rel);
        check("def_valid_cycle1", 32'(rel), 32'd5101);
        check("def_buttonsFF", 32'(btn_d), 32'hFF);
        repeat (3) step();
        check("def_nclk_pulses", 32'(nclk_p_d - b_nclk), 32'd7);
        check("def_high_min", 32'(hi_min_d), 32'd300);
        check("def_high_max", 32'(hi_max_d), 32'd300);
        check("def_period_min", 32'(per_min_d), 32'd600);
        check("def_period_max", 32'(per_max_d), 32'd600);
        $display("default poll 2: valid at cycle %0d buttons=0x%02h", rel, btn_d);

        // Nominal small-parameter poll, pattern A5.
        pat_s = 8'hA5;
        snap_s();
        start_s();
        wait_valid_s(100, rel);
        check("nom_valid_cycle", 32'(rel), 32'd35);
        check("nom_buttons", 32'(btn_s), 32'hA5);
        repeat (3) step();
        check("nom_latch_rise", 32'(lat_rise_s - t0_s + 1), 32'd1);
        check("nom_latch_width", 32'(lat_hi_s - b_lat), 32'd4);
        check("nom_nclk_pulses", 32'(nclk_p_s - b_nclk), 32'd7);
        check("nom_busy_cycles", 32'(busy_c_s - b_busy), 32'd34);
        check("nom_valid_count", 32'(valid_c_s - b_valid), 32'd1);
        check("nom_hold", 32'(btn_s), 32'hA5);
        $display("nominal poll: valid at cycle %0d buttons=0x%02h", rel, btn_s);

        // Enable pulses during the poll are ignored.
        pat_s = 8'h5A;
        snap_s();
        start_s();
        while (cyc - t0_s + 1 < 10) step();
        en_s = 1'b1;
        step();
        en_s = 1'b0;
        while (cyc - t0_s + 1 < 20) step();
        en_s = 1'b1;
        step();
        en_s = 1'b0;
        wait_valid_s(100, rel);
        check("ovr_valid_cycle", 32'(rel), 32'd35);
        check("ovr_buttons", 32'(btn_s), 32'h5A);
        repeat (3) step();
        check("ovr_valid_count", 32'(valid_c_s - b_valid), 32'd1);
        check("ovr_nclk_pulses", 32'(nclk_p_s - b_nclk), 32'd7);
        check("ovr_busy_cycles", 32'(busy_c_s - b_busy), 32'd34);
        check("ovr_latch_width", 32'(lat_hi_s - b_lat), 32'd4);
        $display("enable-during-poll: valid at cycle %0d buttons=0x%02h", rel, btn_s);

        // Mid-poll reset after a poll left 3C.
        pat_s = 8'h3C;
        start_s();
        wait_valid_s(100, rel);
        check("pre_rst_buttons", 32'(btn_s), 32'h3C);
        repeat (2) step();
        snap_s();
        start_s();
        while (cyc - t0_s + 1 < 15) step();
        check("pre_rst_nclk", 32'(nclk_s), 32'd1);
        rst_n = 1'b0;
        step();
        check("midrst_latch", 32'(latch_s), 32'd0);
        check("midrst_nclk", 32'(nclk_s), 32'd0);
        check("midrst_buttons", 32'(btn_s), 32'h00);
        check("midrst_busy", 32'(busy_s), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (30) step();
        check("midrst_no_valid", 32'(valid_c_s - b_valid), 32'd0);
        check("midrst_buttons_held", 32'(btn_s), 32'h00);
        $display("mid-poll reset: buttons=0x%02h", btn_s);
        pat_s = 8'h81;
        start_s();
        wait_valid_s(100, rel);
        check("postrst_valid_cycle", 32'(rel), 32'd35);
        check("postrst_buttons", 32'(btn_s), 32'h81);
        $display("post-reset poll: valid at cycle %0d buttons=0x%02h", rel, btn_s);
        repeat (3) step();

        // Back-to-back polls with enable held high.
        snap_s();
        pat_s = 8'h01;
        en_s  = 1'b1;
        t0_s  = cyc + 1;
        wait_valid_s(100, rel);
        check("b2b_valid_cycle", 32'(rel), 32'd35);
        check("b2b_buttons01", 32'(btn_s), 32'h01);
        $display("back-to-back poll 1: buttons=0x%02h", btn_s);
        pat_s = 8'h80;
        v1    = v_abs;
        step();
        wait_valid_s(100, rel);
        check("b2b_buttons80", 32'(btn_s), 32'h80);
        check("b2b_gap1", 32'(lat_rise_s - v1), 32'd2);
        $display("back-to-back poll 2: buttons=0x%02h", btn_s);
        pat_s = 8'h00;
        v2    = v_abs;
        step();
        wait_valid_s(100, rel);
        en_s = 1'b0;
        check("b2b_buttons00", 32'(btn_s), 32'h00);
        check("b2b_gap2", 32'(lat_rise_s - v2), 32'd2);
        $display("back-to-back poll 3: buttons=0x%02h", btn_s);
        repeat (5) step();
        check("b2b_valid_count", 32'(valid_c_s - b_valid), 32'd3);
        check("b2b_no_fourth", 32'(latch_s), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
